// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM encoding,
// parameter defaults and the idle line level.
package fifo_uart_tx_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    localparam int unsigned DEF_PARITY_EN    = 0;
    localparam int unsigned DEF_STOP_BITS    = 1;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    // Counter width able to hold 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: bit_tick is high in the last clock of every
// CLKS_PER_BIT-clock period; clear restarts the period from zero.
module fifo_uart_tx_baud_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick_c
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // pre_tick_c flags that the coming clock is the last of the bit period.
    always_comb begin
        count_next = count + CW'(1);
        if (clear || (count == LAST)) begin
            count_next = '0;
        end
        pre_tick_c = (count_next == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            bit_tick <= 1'b0;
        end else begin
            count    <= count_next;
            bit_tick <= pre_tick_c;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an sfifo read port and sends each as an async serial
// frame: start, data LSB first, optional even parity, one or two stops.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = DEF_PARITY_EN,
    parameter int unsigned STOP_BITS    = DEF_STOP_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read_n,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BW = cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = (STOP_BITS > 1);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_next;
    logic                  parity;
    logic                  parity_next;
    logic                  stop_cnt;
    logic                  stop_cnt_next;
    logic                  tx_next;
    logic                  read_n_next;
    logic                  busy_next;
    logic                  done_next;
    logic                  baud_clear_c;
    logic                  bit_tick;
    logic                  pre_tick_c;

    // Restart the bit period in LOAD so the start bit gets its full length.
    assign baud_clear_c = (state == ST_LOAD);

    fifo_uart_tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock     (clock),
        .reset     (reset),
        .clear     (baud_clear_c),
        .bit_tick  (bit_tick),
        .pre_tick_c(pre_tick_c)
    );

    // Outputs are registered from next-state values so each lands on the
    // same edge as the state it belongs to.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        parity_next   = parity;
        stop_cnt_next = stop_cnt;
        tx_next       = tx;
        done_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_next = IDLE_LEVEL;
                if (enable && !fifo_empty) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_next    = fifo_data;
                parity_next   = ^fifo_data;
                bit_cnt_next  = '0;
                stop_cnt_next = 1'b0;
                tx_next       = ~IDLE_LEVEL;
                state_next    = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_next    = shreg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_next    = parity;
                            state_next = ST_PARITY;
                        end else begin
                            tx_next    = IDLE_LEVEL;
                            state_next = ST_STOP;
                        end
                    end else begin
                        shreg_next   = shreg >> 1;
                        tx_next      = shreg_next[0];
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    tx_next    = IDLE_LEVEL;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Arm the done pulse one clock early so it sits on the final stop clock.
                if ((stop_cnt == LAST_STOP) && pre_tick_c) begin
                    done_next = 1'b1;
                end
                if (bit_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = ST_IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = IDLE_LEVEL;
            end
        endcase

        read_n_next = (state_next != ST_POP);
        busy_next   = (state_next != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            parity      <= 1'b0;
            stop_cnt    <= 1'b0;
            tx          <= IDLE_LEVEL;
            fifo_read_n <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            bit_cnt     <= bit_cnt_next;
            parity      <= parity_next;
            stop_cnt    <= stop_cnt_next;
            tx          <= tx_next;
            fifo_read_n <= read_n_next;
            busy        <= busy_next;
            frame_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (plain 8N1 and 8E2, both at four
// clocks per bit), each fed by a behavioural sfifo, checked by a frame scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          gap;
    } exp_t;

    logic            clock  = 1'b0;
    logic            reset  = 1'b0;
    logic            enable = 1'b0;
    logic [1:0][7:0] fifo_data  = '0;
    logic [1:0]      fifo_empty = 2'b11;
    logic [1:0]      fifo_read_n;
    logic [1:0]      tx;
    logic [1:0]      busy;
    logic [1:0]      frame_done;
    logic [1:0]      wr_en = 2'b00;
    logic [1:0][7:0] wr_data = '0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       sb0[$];
    exp_t       sb1[$];
    exp_t       cur[2];

    int in_frame[2];
    int sidx[2];
    int gap_cnt[2];
    int bad[2];
    int first_bad[2];
    bit just_ended[2];
    bit prev_rd_low[2];
    int done_cnt[2];
    int rd_cnt[2];
    int rd_long[2];
    int stray_done[2];
    int exp_frames[2];
    int exp_pops[2];
    int pop_empty;
    int idle_viol;
    int checks;
    int failures;

    always #5 clock = ~clock;

    fifo_uart_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
    ) dut0 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fifo_data  (fifo_data[0]),
        .fifo_empty (fifo_empty[0]),
        .fifo_read_n(fifo_read_n[0]),
        .tx         (tx[0]),
        .busy       (busy[0]),
        .frame_done (frame_done[0])
    );

    fifo_uart_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)
    ) dut1 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fifo_data  (fifo_data[1]),
        .fifo_empty (fifo_empty[1]),
        .fifo_read_n(fifo_read_n[1]),
        .tx         (tx[1]),
        .busy       (busy[1]),
        .frame_done (frame_done[1])
    );

    // Behavioural sfifo: byte appears on data_out at the edge that ends the pop.
    always @(posedge clock) begin
        if (fifo_read_n[0] === 1'b0) begin
            if (q0.size() > 0) fifo_data[0] <= q0.pop_front();
            else pop_empty++;
        end
        if (fifo_read_n[1] === 1'b0) begin
            if (q1.size() > 0) fifo_data[1] <= q1.pop_front();
            else pop_empty++;
        end
        if (wr_en[0]) q0.push_back(wr_data[0]);
        if (wr_en[1]) q1.push_back(wr_data[1]);
        fifo_empty[0] <= (q0.size() == 0);
        fifo_empty[1] <= (q1.size() == 0);
    end

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int i);
        exp_t e;
        bit   have;
        int   last;
        logic exp_tx;
        if (reset) begin
            in_frame[i]    = 0;
            sidx[i]        = 0;
            gap_cnt[i]     = 0;
            just_ended[i]  = 0;
            prev_rd_low[i] = 0;
            return;
        end
        if (fifo_read_n[i] == 1'b0) begin
            rd_cnt[i]++;
            if (prev_rd_low[i]) rd_long[i]++;
        end
        prev_rd_low[i] = (fifo_read_n[i] == 1'b0);
        if (in_frame[i] == 0) begin
            if (frame_done[i] !== 1'b0) stray_done[i]++;
            if (just_ended[i]) begin
                just_ended[i] = 0;
                check($sformatf("post_frame_idle%0d", i), busy[i] === 1'b0 && tx[i] === 1'b1,
                      {busy[i], tx[i]}, 2'b01);
            end
            if (tx[i] === 1'b0) begin
                have = 0;
                if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1; end
                if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1; end
                check($sformatf("frame_expected%0d", i), have, have, 1);
                if (have) begin
                    if (e.gap >= 0)
                        check($sformatf("gap%0d_%03h", i, e.bits), gap_cnt[i] == e.gap, gap_cnt[i], e.gap);
                    cur[i]       = e;
                    in_frame[i]  = 1;
                    sidx[i]      = 0;
                    bad[i]       = 0;
                    first_bad[i] = -1;
                end
            end else begin
                gap_cnt[i]++;
            end
        end
        if (in_frame[i] != 0) begin
            last   = cur[i].nbits * CPB - 1;
            exp_tx = cur[i].bits[sidx[i] / CPB];
            if (tx[i] !== exp_tx || frame_done[i] !== (sidx[i] == last) || busy[i] !== 1'b1) begin
                if (first_bad[i] < 0) first_bad[i] = sidx[i];
                bad[i]++;
            end
            if (sidx[i] == last) begin
                check($sformatf("frame%0d_%03h first_bad_sample", i, cur[i].bits), bad[i] == 0,
                      first_bad[i], -1);
                done_cnt[i]++;
                in_frame[i]   = 0;
                gap_cnt[i]    = 0;
                just_ended[i] = 1;
            end
            sidx[i]++;
        end
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) mon_step(i);
    end

    function automatic logic [11:0] bits0(input logic [7:0] d);
        return {2'b00, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [11:0] bits1(input logic [7:0] d);
        return {2'b11, ^d, d, 1'b0};
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic [11:0] bits, input int gap);
        exp_t e;
        e.bits  = bits;
        e.nbits = (i == 0) ? 10 : 12;
        e.gap   = gap;
        wr_en[i]   = 1'b1;
        wr_data[i] = d;
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
        exp_frames[i]++;
        exp_pops[i]++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000) begin
            step();
            n++;
            if (sb0.size() == 0 && sb1.size() == 0 && in_frame[0] == 0 && in_frame[1] == 0 &&
                busy == 2'b00 && fifo_empty == 2'b11) break;
        end
        check("wait_idle_timeout", n < 3000, n, 3000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int r0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_tx%0d", i), tx[i] === 1'b1, tx[i], 1);
            check($sformatf("rst_read_n%0d", i), fifo_read_n[i] === 1'b1, fifo_read_n[i], 1);
            check($sformatf("rst_busy%0d", i), busy[i] === 1'b0, busy[i], 0);
            check($sformatf("rst_done%0d", i), frame_done[i] === 1'b0, frame_done[i], 0);
        end
        enable = 1'b1;

        // Empty FIFO for 50 clocks: line stays quiet.
        repeat (50) begin
            step();
            if (tx !== 2'b11 || fifo_read_n !== 2'b11 || busy !== 2'b00 || frame_done !== 2'b00)
                idle_viol++;
        end
        check("idle_quiet", idle_viol == 0, idle_viol, 0);

        // 0xA5 on the 8N1 instance with latency probes.
        push(0, 8'hA5, 12'h34A, -1);
        step();
        wr_en = '0;
        check("lat_empty", fifo_empty[0] == 1'b0 && fifo_read_n[0] == 1'b1, {fifo_empty[0], fifo_read_n[0]}, 2'b01);
        step();
        check("lat_pop", fifo_read_n[0] == 1'b0, fifo_read_n[0], 0);
        step();
        check("lat_load", fifo_read_n[0] == 1'b1 && tx[0] == 1'b1, {fifo_read_n[0], tx[0]}, 2'b11);
        step();
        check("lat_start", tx[0] == 1'b0, tx[0], 0);
        wait_idle();
        check("a5_single_pop", rd_cnt[0] == 1, rd_cnt[0], 1);
        check("a5_single_done", done_cnt[0] == 1, done_cnt[0], 1);

        // 0x07 on the 8E2 instance: parity 1, two stops, 48 clocks.
        push(1, 8'h07, 12'hE0E, -1);
        step();
        wr_en = '0;
        wait_idle();

        // Sixteen bytes back to back into both instances.
        for (int b = 0; b < 16; b++) begin
            push(0, 8'(b), bits0(8'(b)), (b == 0) ? -1 : 3);
            push(1, 8'(b), bits1(8'(b)), (b == 0) ? -1 : 3);
            step();
        end
        wr_en = '0;
        wait_idle();
        check("fill_empty", fifo_empty == 2'b11, fifo_empty, 2'b11);

        // Drop enable during the data bits of 0x3C.
        push(0, 8'h3C, bits0(8'h3C), -1);
        step();
        push(0, 8'h81, bits0(8'h81), -1);
        step();
        wr_en = '0;
        n = 0;
        while (!(in_frame[0] != 0 && sidx[0] == 3 * CPB) && n < 500) begin step(); n++; end
        check("en_reach_data", n < 500, n, 500);
        enable = 1'b0;
        d0 = done_cnt[0];
        n = 0;
        while (done_cnt[0] == d0 && n < 500) begin step(); n++; end
        check("en_frame_completes", done_cnt[0] == d0 + 1, done_cnt[0], d0 + 1);
        r0 = rd_cnt[0];
        repeat (30) step();
        check("en_no_pop", rd_cnt[0] == r0 && fifo_empty[0] == 1'b0, rd_cnt[0] - r0, 0);
        check("en_idle_line", busy[0] == 1'b0 && tx[0] == 1'b1, {busy[0], tx[0]}, 2'b01);
        enable = 1'b1;
        wait_idle();

        // Reset in the middle of the data bits of 0x5A; 0xC3 follows intact.
        push(0, 8'h5A, bits0(8'h5A), -1);
        step();
        push(0, 8'hC3, bits0(8'hC3), -1);
        step();
        wr_en = '0;
        n = 0;
        while (!(in_frame[0] != 0 && sidx[0] == 6) && n < 500) begin step(); n++; end
        check("rst_reach_data0", tx[0] == 1'b0, tx[0], 0);
        reset = 1'b1;
        #1;
        check("rst_async_tx", tx[0] === 1'b1, tx[0], 1);
        check("rst_async_busy", busy[0] === 1'b0, busy[0], 0);
        exp_frames[0]--;
        step();
        reset = 1'b0;
        check("rst_release_idle", fifo_read_n[0] === 1'b1 && busy[0] === 1'b0, {fifo_read_n[0], busy[0]}, 2'b10);
        wait_idle();

        for (int i = 0; i < 2; i++) begin
            check($sformatf("frames%0d", i), done_cnt[i] == exp_frames[i], done_cnt[i], exp_frames[i]);
            check($sformatf("pops%0d", i), rd_cnt[i] == exp_pops[i], rd_cnt[i], exp_pops[i]);
            check($sformatf("pop_width%0d", i), rd_long[i] == 0, rd_long[i], 0);
            check($sformatf("stray_done%0d", i), stray_done[i] == 0, stray_done[i], 0);
        end
        check("pop_while_empty", pop_empty == 0, pop_empty, 0);
        check("sb_drained", sb0.size() == 0 && sb1.size() == 0, sb0.size() + sb1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
